// File: rtl/alu_pkg.sv
// Shared definitions for the two-pass 16-bit adder.
// Contents: slice and operand widths, operation encodings, sequencer state
// encoding, and a helper that picks the carry into the low byte for an op.
package alu_pkg;

  localparam int unsigned W_HALF = 8;
  localparam int unsigned W      = 2 * W_HALF;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LO   = 2'b01,
    S_HI   = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Subtraction is a + ~b + 1; SBB takes its borrow sense from cin (1 = no borrow-in).
  function automatic logic carry_in0(input logic [1:0] op, input logic cin);
    logic c;
    unique case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      default: c = cin;
    endcase
    return c;
  endfunction

  function automatic logic is_sub(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

endpackage

// File: rtl/add16_seq_if.sv
// Request/response bundle for add16_seq.
// Request side:  in_valid/in_ready handshake with op, cin, a, b.
// Response side: out_valid/out_ready handshake with result, cout, ovf, zero.
// master = requester/consumer, slave = the adder.
interface add16_seq_if;

  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             op;
  logic                   cin;
  logic [alu_pkg::W-1:0]  a;
  logic [alu_pkg::W-1:0]  b;
  logic                   out_valid;
  logic                   out_ready;
  logic [alu_pkg::W-1:0]  result;
  logic                   cout;
  logic                   ovf;
  logic                   zero;

  modport master (
    output in_valid, op, cin, a, b, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero
  );

  modport slave (
    input  in_valid, op, cin, a, b, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero
  );

endinterface

// File: rtl/fadd8.sv
// 8-bit ripple-carry adder slice.
// Ports: a_i, b_i operands; c_i carry in; s_o sum; c_o carry out of bit 7.
module fadd8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  output logic [7:0] s_o,
  output logic       c_o
);

  always_comb begin
    logic c;
    c   = c_i;
    s_o = '0;
    for (int i = 0; i < 8; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    c_o = c;
  end

endmodule

// File: rtl/add16_seq.sv
// Two-pass 16-bit add/subtract on one shared 8-bit ripple adder.
// Ports: clk (rising edge), rst (synchronous, active-high), bus (slave side of
// add16_seq_if carrying the request and result handshakes).
// Sequence: IDLE accepts and latches operands, LO adds the low byte, HI adds the
// high byte with the registered low carry and registers result/flags, DONE
// presents them until out_ready.
module add16_seq
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  add16_seq_if.slave   bus
);

  state_e              state_q;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;        // already inverted for SUB/SBB
  logic                c0_q;
  logic [W_HALF-1:0]   sum_lo_q;
  logic                carry_lo_q;
  logic [W-1:0]        result_q;
  logic                cout_q;
  logic                ovf_q;
  logic                zero_q;
  logic                in_ready_q;
  logic                out_valid_q;

  logic [W_HALF-1:0]   add_a;
  logic [W_HALF-1:0]   add_b;
  logic                add_c;
  logic [W_HALF-1:0]   add_s;
  logic                add_co;

  // Adder inputs held at zero outside LO/HI to keep the slice quiet.
  always_comb begin
    add_a = '0;
    add_b = '0;
    add_c = 1'b0;
    unique case (state_q)
      S_LO: begin
        add_a = a_q[W_HALF-1:0];
        add_b = b_q[W_HALF-1:0];
        add_c = c0_q;
      end
      S_HI: begin
        add_a = a_q[W-1:W_HALF];
        add_b = b_q[W-1:W_HALF];
        add_c = carry_lo_q;
      end
      default: ;
    endcase
  end

  fadd8 u_fadd8 (
    .a_i (add_a),
    .b_i (add_b),
    .c_i (add_c),
    .s_o (add_s),
    .c_o (add_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c0_q        <= 1'b0;
      sum_lo_q    <= '0;
      carry_lo_q  <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= is_sub(bus.op) ? ~bus.b : bus.b;
            c0_q       <= carry_in0(bus.op, bus.cin);
            in_ready_q <= 1'b0;
            state_q    <= S_LO;
          end
        end
        S_LO: begin
          sum_lo_q   <= add_s;
          carry_lo_q <= add_co;
          state_q    <= S_HI;
        end
        S_HI: begin
          result_q    <= {add_s, sum_lo_q};
          cout_q      <= add_co;
          // Overflow: like-signed operands producing a result of the other sign.
          ovf_q       <= (a_q[W-1] == b_q[W-1]) && (add_s[W_HALF-1] != a_q[W-1]);
          zero_q      <= ({add_s, sum_lo_q} == '0);
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_add16_seq.sv
// Directed-vector bench for add16_seq. Inputs are driven and outputs sampled on
// the falling edge; the DUT acts on the rising edge.
module tb_add16_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  add16_seq_if bus ();

  add16_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_result"},    32'(bus.result),    32'd0);
    check({tag, "_cout"},      32'(bus.cout),      32'd0);
    check({tag, "_ovf"},       32'(bus.ovf),       32'd0);
    check({tag, "_zero"},      32'(bus.zero),      32'd0);
  endtask

  // Called at a falling edge with the DUT idle. Returns at the falling edge after
  // the accept edge (DUT in LO) with in_valid dropped and operands scrambled.
  task automatic start_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic cin);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = ~a;
    bus.b        = 16'hdead;
    bus.cin      = ~cin;
    bus.op       = ~op;
    check({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_valid_lo"},      32'(bus.out_valid), 32'd0);
  endtask

  // From LO: one edge to HI, one more to DONE (third edge counting the accept edge).
  task automatic wait_result(input string tag, input logic [15:0] res, input logic c,
                             input logic v, input logic z);
    @(negedge clk);
    check({tag, "_valid_hi"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"},  32'(bus.out_valid), 32'd1);
    check({tag, "_result"}, 32'(bus.result),    32'(res));
    check({tag, "_cout"},   32'(bus.cout),      32'(c));
    check({tag, "_ovf"},    32'(bus.ovf),       32'(v));
    check({tag, "_zero"},   32'(bus.zero),      32'(z));
  endtask

  task automatic ack(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_ack_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_ack_ready"}, 32'(bus.in_ready),  32'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic cin, input logic [15:0] res,
                        input logic c, input logic v, input logic z);
    start_op(tag, op, a, b, cin);
    wait_result(tag, res, c, v, z);
    ack(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = OP_ADD;
    bus.cin       = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_clear("reset");
    rst = 1'b0;

    // out_ready with nothing pending must not disturb the idle block.
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0;
    check("stray_ready_valid", 32'(bus.out_valid), 32'd0);
    check("stray_ready_inrdy", 32'(bus.in_ready),  32'd1);

    //      tag      op      a         b         cin   result    c     v     z
    run_op("add_ch", OP_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    run_op("sub_eq", OP_SUB, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("add_ov", OP_ADD, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("add_wr", OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("adc",    OP_ADC, 16'h1234, 16'h0001, 1'b1, 16'h1236, 1'b0, 1'b0, 1'b0);
    run_op("sbb",    OP_SBB, 16'h1000, 16'h0001, 1'b0, 16'h0FFE, 1'b1, 1'b0, 1'b0);

    // Backpressure: result held in DONE while a new request waits.
    start_op("bp1", OP_ADD, 16'h0001, 16'h0002, 1'b0);
    wait_result("bp1", 16'h0003, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.op       = OP_SUB;
    bus.a        = 16'h0010;
    bus.b        = 16'h0001;
    bus.cin      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready),  32'd0);
      check("bp_valid",    32'(bus.out_valid), 32'd1);
      check("bp_result",   32'(bus.result),    32'h0003);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_idle_ready", 32'(bus.in_ready),  32'd1);
    check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);  // held request accepted on this edge
    bus.in_valid = 1'b0;
    bus.a        = 16'hFFFF;
    check("bp2_in_ready_busy", 32'(bus.in_ready), 32'd0);
    wait_result("bp2", 16'h000F, 1'b1, 1'b0, 1'b0);
    ack("bp2");

    // Reset during LO discards the operation.
    start_op("rst_lo", OP_ADD, 16'h1111, 16'h2222, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_clear("rst_lo");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_lo_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // Reset and request together: reset wins, request not taken.
    bus.in_valid = 1'b1;
    bus.op       = OP_ADD;
    bus.a        = 16'h0001;
    bus.b        = 16'h0001;
    rst          = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_req_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_req_no_valid", 32'(bus.out_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
